motion_update_bcast_sched: RTL
==============================

# motion_update_bcast_sched

Sequences one motion-update phase across the double-buffered position caches. Round-robin arbitrates particle results from NUM_LANES motion-update lanes onto the single broadcast bus (data, destination cell, valid) shared by every position cache. Holds motion_update_enable high for the whole phase, then waits out the caches' particle-count write and buffer swap before reporting done. Sits between the motion-update units and the cell array in the top level.

## Interface
- DATA_WIDTH, 32: width of one coordinate; a particle is {posz, posy, posx}.
- CELL_ID_WIDTH, 4: width of one cell coordinate; destination is {cell_x, cell_y, cell_z}.
- NUM_LANES, 4: number of motion-update requesters (2..8).
- SETTLE_CYCLES, 3: cycles after enable falls before the caches are swapped and readable.
- COUNT_WIDTH, 16: width of broadcast_count.
---
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- start  in  1  one-cycle pulse that begins a phase; ignored unless idle.
- lane_valid  in  NUM_LANES  lane i presents a particle.
- lane_ready  out  NUM_LANES  one-hot grant; transfer when lane_valid[i] && lane_ready[i].
- lane_data  in  NUM_LANES*3*DATA_WIDTH  lane i particle at slice i.
- lane_dst_cell  in  NUM_LANES*3*CELL_ID_WIDTH  lane i destination at slice i.
- lane_done  in  NUM_LANES  level; lane i has no further particles this phase.
- motion_update_enable  out  1  to all caches; high for the whole phase.
- out_data  out  3*DATA_WIDTH  broadcast particle.
- out_data_dst_cell  out  3*CELL_ID_WIDTH  broadcast destination.
- out_data_valid  out  1  broadcast qualifier.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse: caches swapped.
- broadcast_count  out  COUNT_WIDTH  particles broadcast in current/last phase.

## Operation
- States: IDLE, BCAST, FLUSH, SETTLE, DONE.
- IDLE: lane_ready=0, enable=0. start -> BCAST, clear broadcast_count, enable=1 next cycle.
- BCAST: each cycle grant highest-priority lane with lane_valid=1; priority rotates, pointer moves to (granted+1) mod NUM_LANES after each transfer. At most one grant per cycle; lane_ready is combinational from lane_valid and pointer, 0 outside BCAST.
- Transfer cycle N -> out_data/out_data_dst_cell/out_data_valid registered at N+1; out_data_valid=0 with data held 0 when no transfer.
- Exit BCAST when all lane_done=1 and all lane_valid=0 in the same cycle -> FLUSH. lane_valid takes priority over lane_done for the same lane.
- FLUSH: one cycle, enable still 1, emits the last registered beat; -> SETTLE with enable=0.
- SETTLE: count SETTLE_CYCLES, out_data_valid=0; -> DONE.
- DONE: done=1 one cycle, busy=0 next; -> IDLE.
- Empty phase (all lanes done at start): enable still high at least 2 cycles (BCAST, FLUSH) so caches write count 0 and swap.
- broadcast_count increments per transfer, saturates at all-ones.
- start while busy: ignored, no effect.

## Timing
- Reset values: lane_ready=0, enable=0, out_data=0, out_data_dst_cell=0, out_data_valid=0, busy=0, done=0, broadcast_count=0, pointer=0, state IDLE.
- start at cycle 0 -> busy=1, enable=1 at cycle 1.
- Grant-to-broadcast latency 1 cycle; out_data_valid only ever high while enable=1.
- Last enable-high cycle is FLUSH; done pulses SETTLE_CYCLES+1 cycles after enable falls.
- Reset mid-phase: all outputs to reset values next edge; caches are reset separately by their own reset.

## Configuration
- MU_BCAST_STATS_EN: defined -> broadcast_count implemented as above. Undefined -> counter logic removed, broadcast_count tied to 0; all other behaviour identical.

## Structure
- Shared package: state enum, default widths, particle and cell-ID slice helpers (lane index -> bit range).
- One sub-module: rr_arbiter (NUM_LANES request vector + pointer -> one-hot grant, next pointer).

## Test plan
- Empty phase: start, lane_done=4'b1111 -> enable high 2 cycles, no valid, done 4 cycles after enable falls, count 0.
- Single lane: lane 2 sends 3 particles dst {1,2,0} -> 3 beats in order, each 1 cycle after its grant, count 3.
- Contention: all 4 lanes valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; 8 beats back-to-back.
- Valid with done: lane 1 lane_valid=1 and lane_done=1 -> particle still broadcast, then FLUSH.
- start while busy, then rst=0 mid-BCAST -> second start ignored; after reset all outputs 0, state IDLE, next start works.
- Saturation (COUNT_WIDTH=4): 20 transfers -> broadcast_count stops at 15; with MU_BCAST_STATS_EN undefined stays 0.

Source files
------------

// File: rtl/motion_update_bcast_sched_pkg.sv
// Shared types and helpers for the motion-update broadcast scheduler.
// Provides the phase state enum, default widths and per-lane slice offsets.
package motion_update_bcast_sched_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_CELL_ID_WIDTH = 4;
    localparam int DEF_NUM_LANES     = 4;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int DEF_COUNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCAST,
        ST_FLUSH,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // Low bit of lane's {posz, posy, posx} particle inside the packed lane bus.
    function automatic int particle_lo(input int lane, input int data_width);
        return lane * 3 * data_width;
    endfunction

    // Low bit of lane's {cell_x, cell_y, cell_z} destination inside the packed lane bus.
    function automatic int cell_lo(input int lane, input int cell_id_width);
        return lane * 3 * cell_id_width;
    endfunction

endpackage

// File: rtl/motion_update_bcast_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// plus the pointer value that follows that grant.
module motion_update_bcast_sched_rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [PTR_W-1:0]     next_ptr
);

    always_comb begin : arb
        int idx;
        logic found;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % NUM_LANES);
            end
        end
    end

endmodule

// File: rtl/motion_update_bcast_sched.sv
// Sequences one motion-update phase: arbitrates lanes onto the cache broadcast bus,
// then waits out the caches' count write and swap. MU_BCAST_STATS_EN enables broadcast_count.
module motion_update_bcast_sched
    import motion_update_bcast_sched_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CELL_ID_WIDTH = DEF_CELL_ID_WIDTH,
    parameter int NUM_LANES     = DEF_NUM_LANES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_LANES-1:0]                 lane_valid,
    output logic [NUM_LANES-1:0]                 lane_ready,
    input  logic [NUM_LANES*3*DATA_WIDTH-1:0]    lane_data,
    input  logic [NUM_LANES*3*CELL_ID_WIDTH-1:0] lane_dst_cell,
    input  logic [NUM_LANES-1:0]                 lane_done,
    output logic                                 motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [COUNT_WIDTH-1:0]               broadcast_count,
    output state_t                               fsm_state
);

    localparam int PTR_W = $clog2(NUM_LANES);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PW    = 3 * DATA_WIDTH;
    localparam int CW    = 3 * CELL_ID_WIDTH;

    state_t               state, state_next;
    logic [SET_W-1:0]     settle_cnt;
    logic [PTR_W-1:0]     ptr, ptr_next;
    logic [NUM_LANES-1:0] grant;
    logic                 transfer;
    logic                 all_quiet;
    logic [PW-1:0]        sel_data;
    logic [CW-1:0]        sel_dst;

    motion_update_bcast_sched_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_arb (
        .req      (lane_valid),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (ptr_next)
    );

    // Handshake: a particle moves when lane_valid[i] && lane_ready[i]; ready is
    // only ever offered to one valid lane, and only while broadcasting.
    assign lane_ready = (state == ST_BCAST) ? grant : '0;
    assign transfer   = |(lane_valid & lane_ready);
    // A lane still presenting a particle keeps the phase open even if it reports done.
    assign all_quiet  = (&lane_done) && !(|lane_valid);
    assign fsm_state  = state;

    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sel_data = sel_data | (lane_data[particle_lo(i, DATA_WIDTH) +: PW] & {PW{grant[i]}});
            sel_dst  = sel_dst | (lane_dst_cell[cell_lo(i, CELL_ID_WIDTH) +: CW] & {CW{grant[i]}});
        end
    end

    always_comb begin
        state_next           = state;
        motion_update_enable = 1'b0;
        busy                 = 1'b1;
        done                 = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_BCAST;
            end
            ST_BCAST: begin
                motion_update_enable = 1'b1;
                if (all_quiet) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                motion_update_enable = 1'b1;
                state_next           = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            ptr        <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (transfer) ptr <= ptr_next;
        end
    end

    // Broadcast beat lags its grant by one cycle; idle beats carry zero data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data          <= '0;
            out_data_dst_cell <= '0;
            out_data_valid    <= 1'b0;
        end else begin
            out_data_valid    <= transfer;
            out_data          <= transfer ? sel_data : '0;
            out_data_dst_cell <= transfer ? sel_dst : '0;
        end
    end

`ifdef MU_BCAST_STATS_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (state == ST_IDLE && start) begin
            count_q <= '0;
        end else if (transfer && !(&count_q)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign broadcast_count = count_q;
`else
    assign broadcast_count = '0;
`endif

endmodule
